cluster_periph_demux: RTL

CLUSTER_PERIPH_DEMUX -- requirements
Module: cluster_periph_demux

---
 rtl/cluster_periph_demux.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cluster_periph_demux.sv
// Cluster peripheral demultiplexer: routes one master port to NB_SPERIPH slave slots
// (1 KB each), answers unmapped slots locally and keeps responses in grant order.
module cluster_periph_demux #(
  parameter int                    NB_SPERIPH      = 10,
  parameter logic [NB_SPERIPH-1:0] UNMAPPED_MASK   = 10'b00_0000_1000,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [31:0]           ERR_RDATA       = 32'hBADC_AB1E
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [31:0]           add_i,
  input  logic                  wen_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [31:0]           r_rdata_o,
  output logic                  r_opc_o,
  output logic [NB_SPERIPH-1:0] per_req_o,
  output logic [31:0]           per_add_o,
  output logic                  per_wen_o,
  output logic [31:0]           per_wdata_o,
  output logic [3:0]            per_be_o,
  input  logic [NB_SPERIPH-1:0] per_gnt_i,
  input  logic [NB_SPERIPH-1:0] per_r_valid_i,
  input  logic [31:0]           per_r_rdata_i [NB_SPERIPH],
  input  logic [NB_SPERIPH-1:0] per_r_opc_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  // Handshake: a transfer happens in any cycle with req_i && gnt_o; a response is a
  // single cycle with r_valid_o high. Neither side may retract or delay the other.
  typedef struct packed {
    logic       err;
    logic [3:0] slot;
  } tgt_t;

  logic [CW-1:0] cnt;
  tgt_t          last_tgt;
  logic          err_pend;

  logic [3:0] slot;
  logic       slot_mapped;
  tgt_t       tgt;
  logic       sel_gnt;
  logic       sel_rvalid;
  logic       sel_ropc;
  logic [31:0] sel_rdata;
  logic       fwd;
  logic       r_valid_int;
  logic       stall;
  logic       gnt_int;
  logic [NB_SPERIPH-1:0] per_req_int;
  logic       hs;

  assign slot = add_i[13:10];

  always_comb begin
    slot_mapped = 1'b0;
    sel_gnt     = 1'b0;
    for (int i = 0; i < NB_SPERIPH; i++) begin
      if (slot == 4'(i)) begin
        slot_mapped = !UNMAPPED_MASK[i];
        sel_gnt     = per_gnt_i[i];
      end
    end
  end

  assign tgt.err  = !slot_mapped;
  assign tgt.slot = slot_mapped ? slot : 4'd0;

  always_comb begin
    sel_rvalid = 1'b0;
    sel_ropc   = 1'b0;
    sel_rdata  = 32'd0;
    for (int i = 0; i < NB_SPERIPH; i++) begin
      if (last_tgt.slot == 4'(i)) begin
        sel_rvalid = per_r_valid_i[i];
        sel_ropc   = per_r_opc_i[i];
        sel_rdata  = per_r_rdata_i[i];
      end
    end
  end

  assign fwd         = (cnt != '0) && !last_tgt.err;
  assign r_valid_int = err_pend || (fwd && sel_rvalid);

  // A response retiring in this cycle frees a slot, so a full counter does not stall then.
  assign stall = req_i && (((cnt == CW'(MAX_OUTSTANDING)) && !r_valid_int) ||
                           ((cnt != '0) && (tgt != last_tgt)) ||
                           err_pend);

  assign gnt_int = req_i && !stall && (tgt.err || sel_gnt);

  always_comb begin
    per_req_int = '0;
    if (req_i && !stall && !tgt.err) begin
      for (int i = 0; i < NB_SPERIPH; i++) per_req_int[i] = (slot == 4'(i));
    end
  end

  assign gnt_o     = !rst_i && gnt_int;
  assign per_req_o = rst_i ? '0 : per_req_int;
  assign r_valid_o = !rst_i && r_valid_int;
  assign r_opc_o   = r_valid_o && (err_pend || sel_ropc);
  assign r_rdata_o = !r_valid_o ? 32'd0 : (err_pend ? ERR_RDATA : sel_rdata);

  assign per_add_o   = add_i;
  assign per_wen_o   = wen_i;
  assign per_wdata_o = wdata_i;
  assign per_be_o    = be_i;

  assign hs = gnt_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      err_pend <= 1'b0;
      last_tgt <= '0;
    end else begin
      if (hs) last_tgt <= tgt;
      err_pend <= hs && tgt.err;
      case ({hs, r_valid_o})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_no_resp_when_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    r_valid_o |-> (cnt != '0));
  a_cnt_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt <= CW'(MAX_OUTSTANDING));

endmodule
